// File: rtl/vec_mem_pkg.sv
// =============================================================================
// Module      : vec_mem_pkg
// Description : Shared types and constants for the vector memory-access stage.
// Revision    : 1.0
// =============================================================================
`default_nettype none

package vec_mem_pkg;

    localparam int VMU_WIDTH        = 24;
    localparam int VMU_VECTOR_WIDTH = 8;
    localparam int VMU_ADDR_WIDTH   = 16;
    localparam int LANE_IDX_W       = $clog2(VMU_VECTOR_WIDTH);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        DRAIN = 3'd2,
        STORE = 3'd3,
        DONE  = 3'd4
    } vmu_state_t;

    typedef logic [VMU_WIDTH-1:0]                       vmu_lane_t;
    typedef logic [VMU_VECTOR_WIDTH-1:0][VMU_WIDTH-1:0] vmu_vec_t;

endpackage

`default_nettype wire

// File: rtl/vec_lane_reg.sv
// =============================================================================
// Module      : vec_lane_reg
// Description : Lane-addressable vector register with full-vector load and
//               single-lane write.
// Revision    : 1.0
// =============================================================================
`default_nettype none

module vec_lane_reg #(
    parameter int WIDTH = 24,
    parameter int LANES = 8,
    parameter int IDX_W = $clog2(LANES)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_load_all,
    input  logic [LANES-1:0][WIDTH-1:0]  i_vec,
    input  logic                         i_lane_we,
    input  logic [IDX_W-1:0]             i_lane_idx,
    input  logic [WIDTH-1:0]             i_lane_data,
    output logic [LANES-1:0][WIDTH-1:0]  o_vec
);

    logic [LANES-1:0][WIDTH-1:0] r_vec;

    // A full-vector load takes priority over a single-lane write.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vec <= '0;
        end else if (i_load_all) begin
            r_vec <= i_vec;
        end else if (i_lane_we) begin
            for (int i = 0; i < LANES; i++) begin
                if (i_lane_idx == IDX_W'(i)) begin
                    r_vec[i] <= i_lane_data;
                end
            end
        end
    end

    assign o_vec = r_vec;

endmodule

`default_nettype wire

// File: rtl/vector_mem_unit.sv
// =============================================================================
// Module      : vector_mem_unit
// Description : Serialises one vector load/store into per-lane accesses on a
//               word-addressed synchronous RAM, stalling the pipeline meanwhile.
// Revision    : 1.0
// =============================================================================
`default_nettype none

module vector_mem_unit
    import vec_mem_pkg::*;
#(
    parameter int WIDTH        = VMU_WIDTH,
    parameter int VECTOR_WIDTH = VMU_VECTOR_WIDTH,
    parameter int ADDR_WIDTH   = VMU_ADDR_WIDTH
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start_i,
    input  logic                                 is_store_i,
    input  logic [ADDR_WIDTH-1:0]                base_addr_i,
    input  logic [VECTOR_WIDTH-1:0][WIDTH-1:0]   store_data_i,
    output logic [ADDR_WIDTH-1:0]                mem_addr_o,
    output logic                                 mem_we_o,
    output logic [WIDTH-1:0]                     mem_wdata_o,
    input  logic [WIDTH-1:0]                     mem_rdata_i,
    output logic [VECTOR_WIDTH-1:0][WIDTH-1:0]   load_data_o,
    output logic                                 busy_o,
    output logic                                 done_o
);

    localparam int                 c_idx_w     = $clog2(VECTOR_WIDTH);
    localparam logic [c_idx_w-1:0] c_last_lane = c_idx_w'(VECTOR_WIDTH - 1);

    vmu_state_t                       r_state;
    vmu_state_t                       w_state_nxt;
    logic [c_idx_w-1:0]               r_cnt;
    logic [c_idx_w-1:0]               w_cnt_nxt;
    logic [ADDR_WIDTH-1:0]            r_base;
    logic [ADDR_WIDTH-1:0]            r_addr_hold;
    logic [ADDR_WIDTH-1:0]            w_lane_addr;
    logic                             w_accept;
    logic                             w_access;
    logic                             w_cap_we;
    logic [c_idx_w-1:0]               w_cap_idx;
    logic [VECTOR_WIDTH-1:0][WIDTH-1:0] w_store_vec;

    assign w_accept    = (r_state == IDLE) && start_i;
    assign w_access    = (r_state == LOAD) || (r_state == STORE);
    assign w_lane_addr = r_base + ADDR_WIDTH'(r_cnt);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_base      <= '0;
            r_addr_hold <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_base <= base_addr_i;
            end
            // Remember the last issued address so the RAM port is stable when idle.
            if (w_access) begin
                r_addr_hold <= w_lane_addr;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cap_we    = 1'b0;
        w_cap_idx   = r_cnt - 1'b1;
        mem_addr_o  = r_addr_hold;
        mem_we_o    = 1'b0;
        mem_wdata_o = '0;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start_i) begin
                    busy_o      = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = is_store_i ? STORE : LOAD;
                end
            end
            LOAD: begin
                busy_o     = 1'b1;
                mem_addr_o = w_lane_addr;
                // Read data trails its address by one cycle, so lane cnt-1 lands now.
                w_cap_we   = (r_cnt != '0);
                w_cnt_nxt  = r_cnt + 1'b1;
                if (r_cnt == c_last_lane) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                busy_o      = 1'b1;
                w_cap_we    = 1'b1;
                w_cap_idx   = c_last_lane;
                w_state_nxt = DONE;
            end
            STORE: begin
                busy_o      = 1'b1;
                mem_addr_o  = w_lane_addr;
                // A reset arriving mid-store must not let the current lane through.
                mem_we_o    = !reset;
                mem_wdata_o = reset ? '0 : w_store_vec[r_cnt];
                w_cnt_nxt   = r_cnt + 1'b1;
                if (r_cnt == c_last_lane) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                done_o      = !reset;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    vec_lane_reg #(
        .WIDTH (WIDTH),
        .LANES (VECTOR_WIDTH)
    ) u_store_vec (
        .clk         (clk),
        .reset       (reset),
        .i_load_all  (w_accept),
        .i_vec       (store_data_i),
        .i_lane_we   (1'b0),
        .i_lane_idx  ('0),
        .i_lane_data ('0),
        .o_vec       (w_store_vec)
    );

    vec_lane_reg #(
        .WIDTH (WIDTH),
        .LANES (VECTOR_WIDTH)
    ) u_load_vec (
        .clk         (clk),
        .reset       (reset),
        .i_load_all  (1'b0),
        .i_vec       ('0),
        .i_lane_we   (w_cap_we),
        .i_lane_idx  (w_cap_idx),
        .i_lane_data (mem_rdata_i),
        .o_vec       (load_data_o)
    );

endmodule

`default_nettype wire

// File: tb/tb_vector_mem_unit.sv
// =============================================================================
// Module      : tb_vector_mem_unit
// Description : Self-checking bench for vector_mem_unit with a RAM and a
//               behavioural memory/vector reference model.
// Revision    : 1.0
// =============================================================================
`default_nettype none

module tb_vector_mem_unit;

    localparam int W  = 24;
    localparam int N  = 8;
    localparam int AW = 16;

    typedef logic [N-1:0][W-1:0] vec_t;

    typedef struct {
        logic          st;
        logic [AW-1:0] base;
        vec_t          data;
        int            exp_done;
        int            exp_busy;
        logic [W-1:0]  exp_lane0;
    } row_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          start_i;
    logic          is_store_i;
    logic [AW-1:0] base_addr_i;
    vec_t          store_data_i;
    logic [AW-1:0] mem_addr_o;
    logic          mem_we_o;
    logic [W-1:0]  mem_wdata_o;
    logic [W-1:0]  mem_rdata_i;
    vec_t          load_data_o;
    logic          busy_o;
    logic          done_o;

    logic [W-1:0] ram     [0:65535];
    logic [W-1:0] ref_mem [0:65535];
    vec_t         ref_load;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vector_mem_unit dut (
        .clk          (clk),
        .reset        (reset),
        .start_i      (start_i),
        .is_store_i   (is_store_i),
        .base_addr_i  (base_addr_i),
        .store_data_i (store_data_i),
        .mem_addr_o   (mem_addr_o),
        .mem_we_o     (mem_we_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_rdata_i  (mem_rdata_i),
        .load_data_o  (load_data_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    always @(posedge clk) begin
        if (mem_we_o) ram[mem_addr_o] <= mem_wdata_o;
        mem_rdata_i <= ram[mem_addr_o];
    end

    task automatic chk(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic rand_inputs();
        base_addr_i = AW'($urandom);
        is_store_i  = 1'($urandom);
        for (int i = 0; i < N; i++) store_data_i[i] = W'($urandom);
    endtask

    // Reference model: a store updates memory, a load replaces the whole vector.
    task automatic model_op(input logic st, input logic [AW-1:0] b, input vec_t data);
        logic [AW-1:0] a;
        for (int i = 0; i < N; i++) begin
            a = b + AW'(i);
            if (st) ref_mem[a] = data[i];
            else    ref_load[i] = ref_mem[a];
        end
    endtask

    task automatic run_op(input logic st, input logic [AW-1:0] b, input vec_t data,
                          input int exp_done, input int exp_busy);
        int            busy_n;
        int            done_c;
        int            bad;
        logic [AW-1:0] ea;
        busy_n = 0;
        done_c = -1;
        bad    = 0;
        @(negedge clk);
        start_i = 1'b1; is_store_i = st; base_addr_i = b; store_data_i = data;
        #1;
        chk("issue_busy", busy_o, 1);
        if (busy_o) busy_n++;
        for (int c = 1; c <= 20 && done_c < 0; c++) begin
            @(negedge clk);
            start_i = 1'b0;
            rand_inputs();
            #1;
            if (busy_o) busy_n++;
            if (done_o) done_c = c;
            if (c <= 8) begin
                ea = b + AW'(c - 1);
                if (mem_addr_o !== ea || mem_we_o !== st) bad++;
                if (st && mem_wdata_o !== data[c-1]) bad++;
            end else if (mem_we_o !== 1'b0) begin
                bad++;
            end
        end
        model_op(st, b, data);
        chk("done_cycle", done_c, exp_done);
        chk("busy_cycles", busy_n, exp_busy);
        chk("access_seq_errors", bad, 0);
        chk("load_data", load_data_o, ref_load);
        if (st) begin
            bad = 0;
            for (int i = 0; i < N; i++) begin
                ea = b + AW'(i);
                if (ram[ea] !== ref_mem[ea]) bad++;
            end
            chk("ram_contents", bad, 0);
        end
    endtask

    row_t rows[6];

    initial begin
        int            done_c;
        int            bad;
        int            we_n;
        logic [AW-1:0] ea;
        logic [AW-1:0] rb;
        logic          rst;
        vec_t          d;

        for (int a = 0; a < 65536; a++) begin
            ram[a]     = W'($urandom);
            ref_mem[a] = ram[a];
        end
        for (int i = 0; i < N; i++) begin
            ea = 16'h0100 + AW'(i); ram[ea] = 24'h00A000 + W'(i); ref_mem[ea] = ram[ea];
            ea = 16'hFFFC + AW'(i); ram[ea] = 24'hC00000 + W'(i); ref_mem[ea] = ram[ea];
        end
        ref_load = '0;

        rows[0] = '{1'b0, 16'h0100, '0, 10, 10, 24'h00A000};
        rows[1] = '{1'b1, 16'h0200, '0,  9,  9, 24'h00A000};
        rows[2] = '{1'b0, 16'h0200, '0, 10, 10, 24'h111111};
        rows[3] = '{1'b0, 16'hFFFC, '0, 10, 10, 24'hC00000};
        rows[4] = '{1'b1, 16'hFFFE, '0,  9,  9, 24'hC00000};
        rows[5] = '{1'b0, 16'hFFFE, '0, 10, 10, 24'h5A0000};
        for (int i = 0; i < N; i++) begin
            rows[1].data[i] = W'(24'h111111 * (i + 1));
            rows[4].data[i] = 24'h5A0000 + W'(i);
        end

        // Reset and idle behaviour.
        reset = 1'b1; start_i = 1'b0; is_store_i = 1'b0; base_addr_i = '0; store_data_i = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_addr", mem_addr_o, 0);
        chk("rst_we", mem_we_o, 0);
        chk("rst_wdata", mem_wdata_o, 0);
        chk("rst_load_data", load_data_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        start_i = 1'b1;
        #1;
        chk("idle_start_busy", busy_o, 1);
        start_i = 1'b0;

        for (int r = 0; r < 6; r++) begin
            run_op(rows[r].st, rows[r].base, rows[r].data, rows[r].exp_done, rows[r].exp_busy);
            chk("row_lane0", load_data_o[0], rows[r].exp_lane0);
        end

        for (int k = 0; k < 30; k++) begin
            rst = 1'($urandom);
            rb  = ($urandom_range(0, 3) == 0) ? AW'(16'hFFF8 + $urandom_range(0, 7)) : AW'($urandom);
            for (int i = 0; i < N; i++) d[i] = W'($urandom);
            run_op(rst, rb, d, rst ? 9 : 10, rst ? 9 : 10);
        end

        // Reset in cycle 4 of a store.
        for (int i = 0; i < N; i++) d[i] = 24'hE00000 + W'(i);
        we_n = 0;
        @(negedge clk);
        start_i = 1'b1; is_store_i = 1'b1; base_addr_i = 16'h0300; store_data_i = d;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk); start_i = 1'b0; #1;
            if (mem_we_o === 1'b1 && mem_addr_o === 16'h0300 + AW'(c - 1)) we_n++;
        end
        chk("rst_mid_writes", we_n, 3);
        @(negedge clk); reset = 1'b1; #1;
        chk("rst_mid_we_cycle4", mem_we_o, 0);
        @(negedge clk); reset = 1'b0; #1;
        for (int i = 0; i < 3; i++) ref_mem[16'h0300 + AW'(i)] = d[i];
        ref_load = '0;
        chk("rst_mid_busy", busy_o, 0);
        chk("rst_mid_we", mem_we_o, 0);
        chk("rst_mid_addr", mem_addr_o, 0);
        chk("rst_mid_load_data", load_data_o, ref_load);
        done_c = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk); #1;
            if (done_o !== 1'b0 || mem_we_o !== 1'b0) done_c++;
        end
        chk("rst_mid_no_activity", done_c, 0);
        bad = 0;
        for (int i = 0; i < N; i++) begin
            ea = 16'h0300 + AW'(i);
            if (ram[ea] !== ref_mem[ea]) bad++;
        end
        chk("rst_mid_ram", bad, 0);

        // start_i held high: second load accepted only after DONE, base changes ignored.
        bad = 0;
        @(negedge clk);
        start_i = 1'b1; is_store_i = 1'b0; base_addr_i = 16'h0100;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            base_addr_i = AW'($urandom);
            #1;
            if (c <= 8 && mem_addr_o !== 16'h0100 + AW'(c - 1)) bad++;
            if (c <= 9 && (busy_o !== 1'b1 || done_o !== 1'b0)) bad++;
            if (c == 10) begin
                chk("hold_done", done_o, 1);
                chk("hold_done_busy", busy_o, 0);
            end
        end
        chk("hold_addr_errors", bad, 0);
        model_op(1'b0, 16'h0100, '0);
        chk("hold_first_load", load_data_o, ref_load);
        base_addr_i = 16'h0400;
        @(negedge clk); #1;
        chk("hold_second_accept", busy_o, 1);
        done_c = -1;
        for (int c = 12; c <= 30 && done_c < 0; c++) begin
            @(negedge clk); start_i = 1'b0; #1;
            if (done_o) done_c = c;
        end
        chk("hold_second_done", done_c, 21);
        model_op(1'b0, 16'h0400, '0);
        chk("hold_second_load", load_data_o, ref_load);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/vector_mem_unit.md
# vector_mem_unit

Vector memory-access stage. Sits between the execute-stage vector pipeline register and the memory-stage vector pipeline register. It serialises one 8-lane vector load or store into 8 single-word accesses on a 24-bit, word-addressed synchronous RAM. It holds the surrounding vector pipeline registers with `busy_o` until the access completes.

## Interface
- `WIDTH`, 24, lane width in bits (also the RAM word width)
- `VECTOR_WIDTH`, 8, number of lanes
- `ADDR_WIDTH`, 16, RAM word-address width

- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high reset
- `start_i`  in  1  request for a vector memory op; sampled only in IDLE
- `is_store_i`  in  1  1 = store, 0 = load; sampled with `start_i`
- `base_addr_i`  in  ADDR_WIDTH  word address of lane 0; sampled with `start_i`
- `store_data_i`  in  [VECTOR_WIDTH-1:0][WIDTH-1:0]  store vector; sampled with `start_i`
- `mem_addr_o`  out  ADDR_WIDTH  RAM address
- `mem_we_o`  out  1  RAM write enable
- `mem_wdata_o`  out  WIDTH  RAM write data
- `mem_rdata_i`  in  WIDTH  RAM read data, valid 1 cycle after its address
- `load_data_o`  out  [VECTOR_WIDTH-1:0][WIDTH-1:0]  assembled load vector
- `busy_o`  out  1  stall; pipeline register enables = !busy_o
- `done_o`  out  1  1-cycle completion pulse

## Operation
- Lane i maps to address `base + i`, computed modulo 2^ADDR_WIDTH; wrap past all-ones is legal.
- The block latches base, op and store data on acceptance; later changes to the inputs have no effect.
- FSM states and transitions:
  - IDLE: `start_i` leads to LOAD or STORE, with lane counter = 0.
  - LOAD: `mem_addr_o = base + cnt`, `mem_we_o = 0`, cnt++. After cnt = 7, go to DRAIN.
  - DRAIN: capture lane 7, then go to DONE.
  - STORE: `mem_addr_o = base + cnt`, `mem_we_o = 1`, `mem_wdata_o = lane[cnt]`, cnt++. After cnt = 7, go to DONE.
  - DONE: `done_o = 1`, then go to IDLE unconditionally.
- Load capture: `mem_rdata_i` is written into lane cnt-1 on every LOAD cycle with cnt ≥ 1, and into lane 7 in DRAIN.
- `load_data_o` is held between ops. Only lanes written by a load change. A store leaves it untouched.
- `busy_o = (IDLE && start_i) || LOAD || DRAIN || STORE`. This is combinational so the instruction cannot advance on its issue cycle. `busy_o` is 0 in DONE, so the pipeline advances on the DONE cycle.
- `start_i` is ignored in any state other than IDLE.
- Outside STORE: `mem_we_o = 0`, `mem_wdata_o = 0`, `mem_addr_o` = last driven value.

## Timing
- Reset values: `mem_addr_o = 0`, `mem_we_o = 0`, `mem_wdata_o = 0`, `load_data_o` = all lanes 0, `busy_o = 0` (with `start_i` low), `done_o = 0`, state IDLE, cnt 0.
- Load accepted at cycle 0 (IDLE, `start_i` = 1):
  - Addresses are issued in cycles 1–8; lane k is captured at the end of cycle k+2.
  - DRAIN is cycle 9; DONE is cycle 10.
  - `busy_o` is high for cycles 0–9 (10 stall cycles).
- Store accepted at cycle 0: writes in cycles 1–8, DONE in cycle 9, `busy_o` high for cycles 0–8.
- Back-to-back ops: the earliest next acceptance is the cycle after DONE.
- Reset mid-operation wins over everything. At the next edge the block is in IDLE with all outputs at their reset values. No further writes occur, and a partial load is discarded.

## Structure
- Package `vec_mem_pkg` holds:
  - `vmu_state_t` enum {IDLE, LOAD, DRAIN, STORE, DONE}
  - `LANE_IDX_W = $clog2(VECTOR_WIDTH)`
  - lane/vector typedefs parameterised for the defaults
- Sub-module `vec_lane_reg` is the lane-addressable vector register: synchronous reset, single-lane write enable plus lane index, full-vector read. The top block instantiates it twice: once for the latched store vector (full-vector load) and once for the load assembly (single-lane writes).

## Test plan
- Reset then idle: all outputs are 0; with `start_i` = 1 in IDLE, `busy_o` = 1 in the same cycle.
- Load, base 0x0100, RAM[0x100+i] = 0x00A000+i: `done_o` in cycle 10; `load_data_o` lane i = 0x00A000+i; `busy_o` high for exactly 10 cycles.
- Store, base 0x0200, lanes 0x111111·(i+1) masked to 24 bits: 8 consecutive writes to 0x200–0x207 with matching data; `done_o` in cycle 9; `load_data_o` unchanged.
- Wrap: load at base 0xFFFC fetches 0xFFFC–0xFFFF then 0x0000–0x0003, in lane order.
- Reset asserted in cycle 4 of a store: 3 writes only (cycles 1–3); `mem_we_o` = 0 from the next cycle; state IDLE; `done_o` never pulses.
- `start_i` held high continuously: a second op is accepted only in the cycle after DONE, and `base_addr_i` changes mid-op are ignored.
